// File: rtl/spmv_product_stream.sv
// spmv_product_stream
//   Joins the matrix-nonzero stream (a) with the gathered x-vector stream (b), multiplies each
//   pair in a two-stage pipeline and hands the products to a small output FIFO. Operands are
//   admitted only while a FIFO slot is reserved for every in-flight product, so the multiply
//   pipeline never has to stall.
//
//   Optional feature: define SPMV_PRODUCT_COUNT_EN to add io_count, a wrapping 32-bit count of
//   products popped from the output port.
//
// Ports
//   clk           clock, rising edge
//   reset         asynchronous active-high reset
//   io_a_*        nonzero value stream (valid/ready)
//   io_b_*        x value stream (valid/ready)
//   io_out_*      product stream (valid/ready), bits are the FIFO head
//   io_busy       high while any pipeline stage or FIFO entry is occupied
//   io_count      (SPMV_PRODUCT_COUNT_EN only) number of popped products
module spmv_product_stream #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             io_a_valid,
  output logic             io_a_ready,
  input  logic [WIDTH-1:0] io_a_bits,
  input  logic             io_b_valid,
  output logic             io_b_ready,
  input  logic [WIDTH-1:0] io_b_bits,
  output logic             io_out_valid,
  input  logic             io_out_ready,
  output logic [WIDTH-1:0] io_out_bits,
  output logic             io_busy
`ifdef SPMV_PRODUCT_COUNT_EN
  ,
  output logic [31:0]      io_count
`endif
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned OccW = CntW + 1;

  // Pipeline state
  logic             s1_v_q;
  logic [WIDTH-1:0] s1_a_q, s1_b_q;
  logic             s2_v_q;
  logic [WIDTH-1:0] s2_p_q, s2_p_d;

  // FIFO state
  logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q, count_d;
  logic [WIDTH-1:0] last_q;

  logic [OccW-1:0]  occupancy;
  logic             credit_ok;
  logic             fire;
  logic             push;
  logic             pop;

  // Every admitted pair will land in the FIFO two cycles later, so reserve its slot now.
  always_comb begin
    occupancy = OccW'(count_q) + OccW'(s1_v_q) + OccW'(s2_v_q);
    credit_ok = occupancy < OccW'(FIFO_DEPTH);
  end

  // Readies are masked during reset so nothing is reported as consumed while held in reset.
  assign io_a_ready = io_b_valid & credit_ok & ~reset;
  assign io_b_ready = io_a_valid & credit_ok & ~reset;
  assign fire       = io_a_valid & io_b_valid & credit_ok & ~reset;

  assign push         = s2_v_q;
  assign io_out_valid = (count_q != '0);
  assign pop          = io_out_valid & io_out_ready;
  assign io_busy      = s1_v_q | s2_v_q | (count_q != '0);

  // Empty FIFO presents the most recently popped product.
  assign io_out_bits = io_out_valid ? mem_q[rd_ptr_q] : last_q;

  // Product truncated to WIDTH bits (modulo 2^WIDTH).
  assign s2_p_d = s1_a_q * s1_b_q;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_v_q <= 1'b0;
      s1_a_q <= '0;
      s1_b_q <= '0;
      s2_v_q <= 1'b0;
      s2_p_q <= '0;
    end else begin
      s1_v_q <= fire;
      if (fire) begin
        s1_a_q <= io_a_bits;
        s1_b_q <= io_b_bits;
      end
      s2_v_q <= s1_v_q;
      if (s1_v_q) begin
        s2_p_q <= s2_p_d;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      last_q   <= '0;
    end else begin
      count_q <= count_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
        last_q   <= mem_q[rd_ptr_q];
      end
    end
  end

  // Storage needs no reset: entries are only visible while count_q covers them.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= s2_p_q;
    end
  end

`ifdef SPMV_PRODUCT_COUNT_EN
  logic [31:0] pop_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pop_cnt_q <= '0;
    end else if (pop) begin
      pop_cnt_q <= pop_cnt_q + 32'd1;
    end
  end

  assign io_count = pop_cnt_q;
`endif

endmodule

// File: tb/tb_spmv_product_stream.sv
module tb_spmv_product_stream;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned FIFO_DEPTH = 4;

  logic             clk;
  logic             reset;
  logic             io_a_valid;
  logic             io_a_ready;
  logic [WIDTH-1:0] io_a_bits;
  logic             io_b_valid;
  logic             io_b_ready;
  logic [WIDTH-1:0] io_b_bits;
  logic             io_out_valid;
  logic             io_out_ready;
  logic [WIDTH-1:0] io_out_bits;
  logic             io_busy;
`ifdef SPMV_PRODUCT_COUNT_EN
  logic [31:0]      io_count;
`endif

  spmv_product_stream #(
    .WIDTH      (WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .io_a_valid   (io_a_valid),
    .io_a_ready   (io_a_ready),
    .io_a_bits    (io_a_bits),
    .io_b_valid   (io_b_valid),
    .io_b_ready   (io_b_ready),
    .io_b_bits    (io_b_bits),
    .io_out_valid (io_out_valid),
    .io_out_ready (io_out_ready),
    .io_out_bits  (io_out_bits),
    .io_busy      (io_busy)
`ifdef SPMV_PRODUCT_COUNT_EN
    ,
    .io_count     (io_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int n_pops = 0;
  int model_cnt = 0;
  logic [31:0] sb [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Scoreboard: push on observed fire, pop/compare on observed output handshake.
  always @(negedge clk) begin
    logic [63:0] full;
    logic [31:0] exp;
    if (reset) begin
      sb.delete();
      model_cnt = 0;
    end else begin
      if (io_a_valid && io_a_ready && io_b_valid && io_b_ready) begin
        full = 64'(io_a_bits) * 64'(io_b_bits);
        sb.push_back(full[31:0]);
      end
      if (io_out_valid && io_out_ready) begin
        n_pops++;
        model_cnt++;
        if (sb.size() == 0) begin
          chk("unexpected_pop", 64'd1, 64'd0);
        end else begin
          exp = sb.pop_front();
          chk("sb_product", 64'(io_out_bits), 64'(exp));
        end
      end
    end
  end

  // Credits must make a push into a full FIFO impossible.
  always @(negedge clk) begin
    if (!reset && dut.s2_v_q && (int'(dut.count_q) == FIFO_DEPTH)) begin
      chk("push_when_full", 64'd1, 64'd0);
    end
  end

  task automatic wait_idle(input int max_cycles);
    bit done;
    done = 1'b0;
    for (int k = 0; k < max_cycles && !done; k++) begin
      @(negedge clk);
      if (!io_busy) done = 1'b1;
    end
    if (!done) chk("idle_timeout", 64'd1, 64'd0);
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] p;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int fires;
    int j;
    int pops0;
    bit fired;

    vecs[0] = '{a: 32'd3,          b: 32'd5,          p: 32'd15};
    vecs[1] = '{a: 32'hFFFF_FFFF,  b: 32'd2,          p: 32'hFFFF_FFFE};
    vecs[2] = '{a: 32'h0001_0000,  b: 32'h0001_0000,  p: 32'h0000_0000};
    vecs[3] = '{a: 32'h0000_FFFF,  b: 32'h0000_FFFF,  p: 32'hFFFE_0001};
    vecs[4] = '{a: 32'h8000_0000,  b: 32'd3,          p: 32'h8000_0000};
    vecs[5] = '{a: 32'd0,          b: 32'd7,          p: 32'd0};

    reset = 1'b1;
    io_a_valid = 1'b0;
    io_b_valid = 1'b0;
    io_a_bits = '0;
    io_b_bits = '0;
    io_out_ready = 1'b1;
    #2;
    chk("rst_a_ready", 64'(io_a_ready), 64'd0);
    chk("rst_b_ready", 64'(io_b_ready), 64'd0);
    chk("rst_out_valid", 64'(io_out_valid), 64'd0);
    chk("rst_out_bits", 64'(io_out_bits), 64'd0);
    chk("rst_busy", 64'(io_busy), 64'd0);
`ifdef SPMV_PRODUCT_COUNT_EN
    chk("rst_count", 64'(io_count), 64'd0);
`endif
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Single pairs from the table: latency 3, one-cycle pulse, busy clears.
    for (int v = 0; v < 6; v++) begin
      @(posedge clk); #1;
      io_a_valid = 1'b1; io_b_valid = 1'b1;
      io_a_bits = vecs[v].a; io_b_bits = vecs[v].b;
      @(negedge clk);
      chk("vec_a_ready", 64'(io_a_ready), 64'd1);
      @(posedge clk); #1;
      io_a_valid = 1'b0; io_b_valid = 1'b0;
      @(negedge clk);
      chk("vec_lat_n1", 64'(io_out_valid), 64'd0);
      @(negedge clk);
      chk("vec_lat_n2", 64'(io_out_valid), 64'd0);
      @(negedge clk);
      chk("vec_lat_n3", 64'(io_out_valid), 64'd1);
      chk("vec_bits", 64'(io_out_bits), 64'(vecs[v].p));
      @(negedge clk);
      chk("vec_pulse", 64'(io_out_valid), 64'd0);
      chk("vec_busy", 64'(io_busy), 64'd0);
      chk("vec_hold_bits", 64'(io_out_bits), 64'(vecs[v].p));
    end

    // Back-to-back stream: a_ready stays high, one product per cycle.
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (c < 8) begin
        io_a_valid = 1'b1; io_b_valid = 1'b1;
        io_a_bits = 32'(c); io_b_bits = 32'(c + 1);
      end else begin
        io_a_valid = 1'b0; io_b_valid = 1'b0;
      end
      @(negedge clk);
      if (c < 8) chk("b2b_a_ready", 64'(io_a_ready), 64'd1);
      chk("b2b_out_valid", 64'(io_out_valid), 64'((c >= 3 && c <= 10) ? 1 : 0));
    end
    wait_idle(20);

    // Backpressure: exactly FIFO_DEPTH fires, then drain in order.
    pops0 = n_pops;
    fires = 0;
    j = 0;
    @(posedge clk); #1;
    io_out_ready = 1'b0;
    io_a_valid = 1'b1; io_b_valid = 1'b1;
    io_a_bits = 32'd10; io_b_bits = 32'd2;
    for (int cyc = 0; cyc < 80 && j < 10; cyc++) begin
      @(negedge clk);
      fired = io_a_ready & io_b_ready;
      if (fired) fires++;
      if (cyc == 11) begin
        chk("bp_fires", 64'(fires), 64'(FIFO_DEPTH));
        chk("bp_a_ready", 64'(io_a_ready), 64'd0);
        chk("bp_b_ready", 64'(io_b_ready), 64'd0);
        chk("bp_out_valid", 64'(io_out_valid), 64'd1);
      end
      @(posedge clk); #1;
      if (cyc == 11) io_out_ready = 1'b1;
      if (fired) begin
        j++;
        io_a_bits = 32'(10 + j);
        io_b_bits = 32'(2 + j);
        if (j == 10) begin
          io_a_valid = 1'b0; io_b_valid = 1'b0;
        end
      end
    end
    chk("bp_all_fired", 64'(j), 64'd10);
    wait_idle(30);
    chk("bp_pops", 64'(n_pops - pops0), 64'd10);

    // Lone valid is never consumed; join fires the cycle the partner arrives.
    @(posedge clk); #1;
    io_a_valid = 1'b1; io_a_bits = 32'd9; io_b_bits = 32'd4;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("lone_a_ready", 64'(io_a_ready), 64'd0);
      @(posedge clk); #1;
    end
    chk("lone_busy", 64'(io_busy), 64'd0);
    io_b_valid = 1'b1;
    @(negedge clk);
    chk("join_a_ready", 64'(io_a_ready), 64'd1);
    chk("join_b_ready", 64'(io_b_ready), 64'd1);
    @(posedge clk); #1;
    io_a_valid = 1'b0; io_b_valid = 1'b0;
    wait_idle(20);

`ifdef SPMV_PRODUCT_COUNT_EN
    @(negedge clk);
    chk("count_model", 64'(io_count), 64'(model_cnt));
`endif

    // Reset mid-stream with products in the pipe and FIFO.
    @(posedge clk); #1;
    io_out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      io_a_valid = 1'b1; io_b_valid = 1'b1;
      io_a_bits = 32'(c + 100); io_b_bits = 32'd3;
      @(posedge clk); #1;
    end
    io_a_valid = 1'b0; io_b_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #3;
    chk("pre_rst_out_valid", 64'(io_out_valid), 64'd1);
    reset = 1'b1;
    #1;
    chk("mid_rst_out_valid", 64'(io_out_valid), 64'd0);
    chk("mid_rst_busy", 64'(io_busy), 64'd0);
`ifdef SPMV_PRODUCT_COUNT_EN
    chk("mid_rst_count", 64'(io_count), 64'd0);
`endif
    @(posedge clk); #1;
    reset = 1'b0;
    io_out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("post_rst_out_valid", 64'(io_out_valid), 64'd0);
      chk("post_rst_busy", 64'(io_busy), 64'd0);
    end

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
